id_ctrl_pipe: RTL and testbench

ID_CTRL_PIPE -- requirements
Module: id_ctrl_pipe

---
 rtl/id_ctrl_pipe.sv | 239 +++++++++++++++++++++++
 tb/tb_id_ctrl_pipe.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ctrl_pipe.sv
// RV32I decode stage with ID/EX control register and load-use interlock.
// Latency: one cycle from an accepted if_inst to ex_valid.
// Backpressure: holds ID/EX while ex_ready is low; inserts one bubble on load-use; ex_flush kills ID.
module id_ctrl_pipe #(
  parameter int INST_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int HALF_EN        = 1,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      if_valid,
  input  logic [INST_WIDTH-1:0]     if_inst,
  output logic                      if_ready,
  input  logic                      ex_ready,
  input  logic                      ex_flush,
  output logic                      ex_valid,
  output logic                      ex_reg_write,
  output logic                      ex_alu_src,
  output logic                      ex_read1_src,
  output logic                      ex_comp_unsigned,
  output logic                      ex_alu_out,
  output logic                      ex_memory_rd,
  output logic                      ex_memory_wr,
  output logic                      ex_load_unsigned,
  output logic                      ex_branch,
  output logic                      ex_jal,
  output logic                      ex_jalr,
  output logic                      ex_auipc,
  output logic                      ex_illegal,
  output logic [1:0]                ex_mem_size,
  output logic [1:0]                ex_reg_wr_src,
  output logic [REG_ADDR_WIDTH-1:0] ex_rd,
  output logic [REG_ADDR_WIDTH-1:0] ex_rs1,
  output logic [REG_ADDR_WIDTH-1:0] ex_rs2,
  output logic [CNT_WIDTH-1:0]      stall_cnt
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef struct packed {
    logic                      reg_write;
    logic                      alu_src;
    logic                      read1_src;
    logic                      comp_unsigned;
    logic                      alu_out;
    logic                      memory_rd;
    logic                      memory_wr;
    logic                      load_unsigned;
    logic                      branch;
    logic                      jal;
    logic                      jalr;
    logic                      auipc;
    logic                      illegal;
    logic [1:0]                mem_size;
    logic [1:0]                reg_wr_src;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic [REG_ADDR_WIDTH-1:0] rs1;
    logic [REG_ADDR_WIDTH-1:0] rs2;
  } ctrl_t;

  logic [6:0]     opcode;
  logic [2:0]     funct3;
  logic [6:0]     funct7;
  logic           half_ok;
  logic           legal;
  logic           rs1_used;
  logic           rs2_used;
  ctrl_t          dec;
  ctrl_t          ctrl_d, ctrl_q;
  logic           ex_valid_d, ex_valid_q;
  logic [CNT_WIDTH-1:0] stall_cnt_d, stall_cnt_q;
  logic           hazard;
  logic           advance;

  assign opcode  = if_inst[6:0];
  assign funct3  = if_inst[14:12];
  assign funct7  = if_inst[31:25];
  assign half_ok = (HALF_EN != 0);

  // Combinational RV32I field decode of the instruction sitting in ID.
  always_comb begin
    dec          = '0;
    legal        = 1'b0;
    rs1_used     = 1'b1;
    rs2_used     = 1'b0;
    dec.rd       = if_inst[7  +: REG_ADDR_WIDTH];
    dec.rs1      = if_inst[15 +: REG_ADDR_WIDTH];
    dec.rs2      = if_inst[20 +: REG_ADDR_WIDTH];
    case (opcode)
      OP_R: begin
        legal             = (funct7 == 7'h00) ||
                            ((funct7 == 7'h20) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
        dec.reg_write     = 1'b1;
        dec.comp_unsigned = (funct3 == 3'b011);
        dec.alu_out       = (funct3 == 3'b010) || (funct3 == 3'b011);
        rs2_used          = 1'b1;
      end
      OP_IMM: begin
        // Only the shift-immediates constrain funct7 (SLLI, SRLI/SRAI).
        if (funct3 == 3'b001)      legal = (funct7 == 7'h00);
        else if (funct3 == 3'b101) legal = (funct7 == 7'h00) || (funct7 == 7'h20);
        else                       legal = 1'b1;
        dec.reg_write     = 1'b1;
        dec.alu_src       = 1'b1;
        dec.comp_unsigned = (funct3 == 3'b011);
        dec.alu_out       = (funct3 == 3'b010) || (funct3 == 3'b011);
      end
      OP_LOAD: begin
        legal             = (funct3 == 3'b000) || (funct3 == 3'b010) || (funct3 == 3'b100) ||
                            (half_ok && ((funct3 == 3'b001) || (funct3 == 3'b101)));
        dec.reg_write     = 1'b1;
        dec.alu_src       = 1'b1;
        dec.memory_rd     = 1'b1;
        dec.load_unsigned = funct3[2];
        dec.mem_size      = funct3[1:0];
        dec.reg_wr_src    = 2'b10;
      end
      OP_STORE: begin
        legal        = (funct3 == 3'b000) || (funct3 == 3'b010) || (half_ok && (funct3 == 3'b001));
        dec.alu_src   = 1'b1;
        dec.memory_wr = 1'b1;
        dec.mem_size  = funct3[1:0];
        rs2_used      = 1'b1;
      end
      OP_BRANCH: begin
        legal             = (funct3[2:1] != 2'b01);
        dec.branch        = 1'b1;
        dec.comp_unsigned = (funct3[2:1] == 2'b11);
        dec.alu_out       = funct3[2];
        rs2_used          = 1'b1;
      end
      OP_LUI: begin
        legal         = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.read1_src = 1'b1;
        rs1_used      = 1'b0;
      end
      OP_AUIPC: begin
        legal         = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.auipc     = 1'b1;
        rs1_used      = 1'b0;
      end
      OP_JAL: begin
        legal          = 1'b1;
        dec.reg_write  = 1'b1;
        dec.jal        = 1'b1;
        dec.reg_wr_src = 2'b11;
        rs1_used       = 1'b0;
      end
      OP_JALR: begin
        legal          = (funct3 == 3'b000);
        dec.reg_write  = 1'b1;
        dec.alu_src    = 1'b1;
        dec.jalr       = 1'b1;
        dec.reg_wr_src = 2'b11;
      end
      default: legal = 1'b0;
    endcase
    // Illegal encodings must not touch architectural state.
    if (!legal) begin
      dec.illegal   = 1'b1;
      dec.reg_write = 1'b0;
      dec.memory_rd = 1'b0;
      dec.memory_wr = 1'b0;
    end
    // Writes to x0 are dropped here so EX never sees them.
    if (dec.rd == '0) dec.reg_write = 1'b0;
  end

  assign hazard   = if_valid && ex_valid_q && ctrl_q.memory_rd && (ctrl_q.rd != '0) &&
                    ((rs1_used && (dec.rs1 == ctrl_q.rd)) || (rs2_used && (dec.rs2 == ctrl_q.rd)));
  assign advance  = ex_ready || !ex_valid_q;
  assign if_ready = ex_flush || (advance && !hazard);

  // Next-state for ID/EX: flush beats hold, hold beats bubble, bubble beats load.
  always_comb begin
    ex_valid_d  = ex_valid_q;
    ctrl_d      = ctrl_q;
    stall_cnt_d = stall_cnt_q;
    if (ex_flush) begin
      ex_valid_d = 1'b0;
    end else if (advance) begin
      if (hazard) begin
        ex_valid_d = 1'b0;
        if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end else begin
        ex_valid_d = if_valid;
        ctrl_d     = dec;
      end
    end
  end

  // ID/EX register and stall counter with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q  <= 1'b0;
      ctrl_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      ex_valid_q  <= ex_valid_d;
      ctrl_q      <= ctrl_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign ex_valid         = ex_valid_q;
  assign ex_reg_write     = ctrl_q.reg_write;
  assign ex_alu_src       = ctrl_q.alu_src;
  assign ex_read1_src     = ctrl_q.read1_src;
  assign ex_comp_unsigned = ctrl_q.comp_unsigned;
  assign ex_alu_out       = ctrl_q.alu_out;
  assign ex_memory_rd     = ctrl_q.memory_rd;
  assign ex_memory_wr     = ctrl_q.memory_wr;
  assign ex_load_unsigned = ctrl_q.load_unsigned;
  assign ex_branch        = ctrl_q.branch;
  assign ex_jal           = ctrl_q.jal;
  assign ex_jalr          = ctrl_q.jalr;
  assign ex_auipc         = ctrl_q.auipc;
  assign ex_illegal       = ctrl_q.illegal;
  assign ex_mem_size      = ctrl_q.mem_size;
  assign ex_reg_wr_src    = ctrl_q.reg_wr_src;
  assign ex_rd            = ctrl_q.rd;
  assign ex_rs1           = ctrl_q.rs1;
  assign ex_rs2           = ctrl_q.rs2;
  assign stall_cnt        = stall_cnt_q;

endmodule

// File: tb/tb_id_ctrl_pipe.sv
// Scoreboard bench for id_ctrl_pipe: default, HALF_EN=0 and CNT_WIDTH=2 instances share stimulus.
// Expected EX bundles are pushed on acceptance and popped by a monitor on each EX handshake.
// Direct checks cover reset, stalls, flush, counter saturation and mid-stall reset.
module tb_id_ctrl_pipe;

  logic        clk, rst, if_valid, ex_ready, ex_flush;
  logic [31:0] if_inst;

  // default instance
  logic if_ready, ex_valid, ex_reg_write, ex_alu_src, ex_read1_src, ex_comp_unsigned, ex_alu_out;
  logic ex_memory_rd, ex_memory_wr, ex_load_unsigned, ex_branch, ex_jal, ex_jalr, ex_auipc, ex_illegal;
  logic [1:0] ex_mem_size, ex_reg_wr_src;
  logic [4:0] ex_rd, ex_rs1, ex_rs2;
  logic [15:0] stall_cnt;
  // HALF_EN=0 instance
  logic n_if_ready, n_ex_valid, n_ex_reg_write, n_ex_alu_src, n_ex_read1_src, n_ex_comp_unsigned, n_ex_alu_out;
  logic n_ex_memory_rd, n_ex_memory_wr, n_ex_load_unsigned, n_ex_branch, n_ex_jal, n_ex_jalr, n_ex_auipc, n_ex_illegal;
  logic [1:0] n_ex_mem_size, n_ex_reg_wr_src;
  logic [4:0] n_ex_rd, n_ex_rs1, n_ex_rs2;
  logic [15:0] n_stall_cnt;
  // CNT_WIDTH=2 instance
  logic c_if_ready, c_ex_valid, c_ex_reg_write, c_ex_alu_src, c_ex_read1_src, c_ex_comp_unsigned, c_ex_alu_out;
  logic c_ex_memory_rd, c_ex_memory_wr, c_ex_load_unsigned, c_ex_branch, c_ex_jal, c_ex_jalr, c_ex_auipc, c_ex_illegal;
  logic [1:0] c_ex_mem_size, c_ex_reg_wr_src;
  logic [4:0] c_ex_rd, c_ex_rs1, c_ex_rs2;
  logic [1:0] c_stall_cnt;

  id_ctrl_pipe u_dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_inst(if_inst), .if_ready(if_ready),
    .ex_ready(ex_ready), .ex_flush(ex_flush), .ex_valid(ex_valid), .ex_reg_write(ex_reg_write),
    .ex_alu_src(ex_alu_src), .ex_read1_src(ex_read1_src), .ex_comp_unsigned(ex_comp_unsigned),
    .ex_alu_out(ex_alu_out), .ex_memory_rd(ex_memory_rd), .ex_memory_wr(ex_memory_wr),
    .ex_load_unsigned(ex_load_unsigned), .ex_branch(ex_branch), .ex_jal(ex_jal), .ex_jalr(ex_jalr),
    .ex_auipc(ex_auipc), .ex_illegal(ex_illegal), .ex_mem_size(ex_mem_size), .ex_reg_wr_src(ex_reg_wr_src),
    .ex_rd(ex_rd), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .stall_cnt(stall_cnt)
  );

  id_ctrl_pipe #(.HALF_EN(0)) u_nohalf (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_inst(if_inst), .if_ready(n_if_ready),
    .ex_ready(ex_ready), .ex_flush(ex_flush), .ex_valid(n_ex_valid), .ex_reg_write(n_ex_reg_write),
    .ex_alu_src(n_ex_alu_src), .ex_read1_src(n_ex_read1_src), .ex_comp_unsigned(n_ex_comp_unsigned),
    .ex_alu_out(n_ex_alu_out), .ex_memory_rd(n_ex_memory_rd), .ex_memory_wr(n_ex_memory_wr),
    .ex_load_unsigned(n_ex_load_unsigned), .ex_branch(n_ex_branch), .ex_jal(n_ex_jal), .ex_jalr(n_ex_jalr),
    .ex_auipc(n_ex_auipc), .ex_illegal(n_ex_illegal), .ex_mem_size(n_ex_mem_size), .ex_reg_wr_src(n_ex_reg_wr_src),
    .ex_rd(n_ex_rd), .ex_rs1(n_ex_rs1), .ex_rs2(n_ex_rs2), .stall_cnt(n_stall_cnt)
  );

  id_ctrl_pipe #(.CNT_WIDTH(2)) u_cnt2 (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_inst(if_inst), .if_ready(c_if_ready),
    .ex_ready(ex_ready), .ex_flush(ex_flush), .ex_valid(c_ex_valid), .ex_reg_write(c_ex_reg_write),
    .ex_alu_src(c_ex_alu_src), .ex_read1_src(c_ex_read1_src), .ex_comp_unsigned(c_ex_comp_unsigned),
    .ex_alu_out(c_ex_alu_out), .ex_memory_rd(c_ex_memory_rd), .ex_memory_wr(c_ex_memory_wr),
    .ex_load_unsigned(c_ex_load_unsigned), .ex_branch(c_ex_branch), .ex_jal(c_ex_jal), .ex_jalr(c_ex_jalr),
    .ex_auipc(c_ex_auipc), .ex_illegal(c_ex_illegal), .ex_mem_size(c_ex_mem_size), .ex_reg_wr_src(c_ex_reg_wr_src),
    .ex_rd(c_ex_rd), .ex_rs1(c_ex_rs1), .ex_rs2(c_ex_rs2), .stall_cnt(c_stall_cnt)
  );

  // EX bundle: {reg_write, alu_src, read1_src, comp_unsigned, alu_out, memory_rd, memory_wr,
  //             load_unsigned, branch, jal, jalr, auipc, illegal, mem_size, reg_wr_src, rd, rs1, rs2}
  logic [31:0] bus;
  assign bus = {ex_reg_write, ex_alu_src, ex_read1_src, ex_comp_unsigned, ex_alu_out, ex_memory_rd,
                ex_memory_wr, ex_load_unsigned, ex_branch, ex_jal, ex_jalr, ex_auipc, ex_illegal,
                ex_mem_size, ex_reg_wr_src, ex_rd, ex_rs1, ex_rs2};

  function automatic logic [31:0] e(input logic [12:0] flags, input logic [1:0] ms, input logic [1:0] ws,
                                    input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    return {flags, ms, ws, rd, rs1, rs2};
  endfunction

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] sb[$];
  logic [31:0] m_exp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached with %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  // Monitor: every EX handshake must match the oldest expected bundle.
  always @(negedge clk) begin
    if (!rst && ex_valid && ex_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL ex_out: got %h expected no output", bus);
      end else begin
        m_exp = sb.pop_front();
        chk("ex_out", bus, m_exp);
      end
    end
  end

  // Present inst until accepted; push its expected bundle and check the number of stall cycles.
  task automatic issue(input string name, input logic [31:0] inst, input logic [31:0] exp, input int exp_wait);
    int  waits = 0;
    bit  done  = 0;
    if_valid = 1'b1;
    if_inst  = inst;
    while (!done) begin
      @(negedge clk);
      if (if_ready) begin
        sb.push_back(exp);
        done = 1;
      end else begin
        waits++;
      end
      @(posedge clk); #1;
      if (!done && waits > 20) begin
        n_checks++;
        $display("FAIL %s accept: got no if_ready after %0d cycles expected acceptance", name, waits);
        done = 1;
      end
    end
    if_valid = 1'b0;
    chk({name, " wait"}, 32'(waits), 32'(exp_wait));
  endtask

  localparam logic [31:0] I_ADD3  = 32'h002081B3;  // ADD  x3,x1,x2
  localparam logic [31:0] I_LW5   = 32'h0000A283;  // LW   x5,0(x1)
  localparam logic [31:0] I_ADD6  = 32'h00128333;  // ADD  x6,x5,x1
  localparam logic [31:0] I_SLTU  = 32'h00A4B433;  // SLTU x8,x9,x10
  localparam logic [31:0] I_SW    = 32'h0020A223;  // SW   x2,4(x1)
  localparam logic [31:0] I_BLTU  = 32'h0020E463;  // BLTU x1,x2,8
  localparam logic [31:0] I_JAL   = 32'h000000EF;  // JAL  x1,0
  localparam logic [31:0] I_LUI0  = 32'h12345037;  // LUI  x0,0x12345
  localparam logic [31:0] I_BAD   = 32'hFFFFFFFF;  // unknown opcode
  localparam logic [31:0] I_LBU   = 32'h0001C203;  // LBU  x4,0(x3)
  localparam logic [31:0] I_LH    = 32'h00211383;  // LH   x7,2(x2)

  logic [31:0] e_add3, e_lw5, e_add6, e_sltu, e_sw, e_bltu, e_jal, e_lui0, e_bad, e_lbu, e_lh;
  int exp_cnt;

  initial begin
    e_add3 = e(13'b1000000000000, 2'b00, 2'b00, 5'd3,  5'd1,  5'd2);
    e_lw5  = e(13'b1100010000000, 2'b10, 2'b10, 5'd5,  5'd1,  5'd0);
    e_add6 = e(13'b1000000000000, 2'b00, 2'b00, 5'd6,  5'd5,  5'd1);
    e_sltu = e(13'b1001100000000, 2'b00, 2'b00, 5'd8,  5'd9,  5'd10);
    e_sw   = e(13'b0100001000000, 2'b10, 2'b00, 5'd4,  5'd1,  5'd2);
    e_bltu = e(13'b0001100010000, 2'b00, 2'b00, 5'd8,  5'd1,  5'd2);
    e_jal  = e(13'b1000000001000, 2'b00, 2'b11, 5'd1,  5'd0,  5'd0);
    e_lui0 = e(13'b0110000000000, 2'b00, 2'b00, 5'd0,  5'd8,  5'd3);
    e_bad  = e(13'b0000000000001, 2'b00, 2'b00, 5'd31, 5'd31, 5'd31);
    e_lbu  = e(13'b1100010100000, 2'b00, 2'b10, 5'd4,  5'd3,  5'd0);
    e_lh   = e(13'b1100010000000, 2'b01, 2'b10, 5'd7,  5'd2,  5'd2);

    rst = 1'b1; if_valid = 1'b0; if_inst = 32'h0; ex_ready = 1'b1; ex_flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset bus", bus, 32'h0);
    chk("reset ex_valid", 32'(ex_valid), 32'd0);
    chk("reset stall_cnt", 32'(stall_cnt), 32'd0);
    chk("reset if_ready", 32'(if_ready), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;

    // Basic ALU op, then load-use: exactly one stall cycle and one bubble.
    issue("add3", I_ADD3, e_add3, 0);
    issue("lw5",  I_LW5,  e_lw5,  0);
    issue("add6", I_ADD6, e_add6, 1);
    @(negedge clk);
    chk("stall_cnt after load-use", 32'(stall_cnt), 32'd1);
    chk("cnt2 after load-use", 32'(c_stall_cnt), 32'd1);
    @(posedge clk); #1;

    // EX backpressure for 3 cycles: ID/EX holds, ID refuses the next instruction.
    issue("sltu", I_SLTU, e_sltu, 0);
    ex_ready = 1'b0;
    if_valid = 1'b1;
    if_inst  = I_SW;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold if_ready", 32'(if_ready), 32'd0);
      chk("hold ex_valid", 32'(ex_valid), 32'd1);
      chk("hold bus", bus, e_sltu);
      @(posedge clk); #1;
    end
    ex_ready = 1'b1;
    issue("sw", I_SW, e_sw, 0);

    // Mixed decode patterns, including x0 write suppression and an unknown opcode.
    issue("bltu", I_BLTU, e_bltu, 0);
    issue("jal",  I_JAL,  e_jal,  0);
    issue("lui0", I_LUI0, e_lui0, 0);
    issue("bad",  I_BAD,  e_bad,  0);
    issue("lbu",  I_LBU,  e_lbu,  0);
    issue("lh",   I_LH,   e_lh,   0);
    @(negedge clk);
    chk("nohalf lh ex_valid", 32'(n_ex_valid), 32'd1);
    chk("nohalf lh illegal", 32'(n_ex_illegal), 32'd1);
    chk("nohalf lh memory_rd", 32'(n_ex_memory_rd), 32'd0);
    chk("nohalf lh reg_write", 32'(n_ex_reg_write), 32'd0);
    @(posedge clk); #1;

    // Flush coinciding with a load-use hazard: ID accepts and discards, no stall counted.
    issue("lw5 flush", I_LW5, e_lw5, 0);
    if_valid = 1'b1;
    if_inst  = I_ADD6;
    ex_flush = 1'b1;
    @(negedge clk);
    chk("flush if_ready", 32'(if_ready), 32'd1);
    @(posedge clk); #1;
    ex_flush = 1'b0;
    if_valid = 1'b0;
    @(negedge clk);
    chk("flush ex_valid", 32'(ex_valid), 32'd0);
    chk("flush stall_cnt", 32'(stall_cnt), 32'd1);
    @(posedge clk); #1;

    // Five more load-use pairs: 16-bit counter climbs, 2-bit counter saturates at 3.
    exp_cnt = 1;
    for (int k = 0; k < 5; k++) begin
      issue("sat lw5", I_LW5, e_lw5, 0);
      issue("sat add6", I_ADD6, e_add6, 1);
      exp_cnt++;
      @(negedge clk);
      chk("sat stall_cnt", 32'(stall_cnt), 32'(exp_cnt));
      chk("sat cnt2", 32'(c_stall_cnt), (exp_cnt > 3) ? 32'd3 : 32'(exp_cnt));
      @(posedge clk); #1;
    end

    // Reset in the middle of a stalled load-use with EX backpressured.
    issue("lw5 rst", I_LW5, e_lw5, 0);
    ex_ready = 1'b0;
    if_valid = 1'b1;
    if_inst  = I_ADD6;
    @(negedge clk);
    chk("pre-reset if_ready", 32'(if_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    @(negedge clk);
    chk("midreset bus", bus, 32'h0);
    chk("midreset ex_valid", 32'(ex_valid), 32'd0);
    chk("midreset stall_cnt", 32'(stall_cnt), 32'd0);
    chk("midreset cnt2", 32'(c_stall_cnt), 32'd0);
    chk("midreset if_ready", 32'(if_ready), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    if_valid = 1'b0;
    ex_ready = 1'b1;
    @(posedge clk); #1;
    issue("add3 post-reset", I_ADD3, e_add3, 0);
    @(negedge clk);
    @(posedge clk); #1;

    chk("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
